serial_stream_arbiter: RTL and testbench

- Shares one serial bit-stream state machine (single input X, single combinational output Y, clocked on clk) between two requesters.
- Grants round-robin and latches the winner's W-bit word.
- Shifts the word LSB-first into the machine's X, one bit per cycle, and captures Y each cycle into a response word.
- Returns the response with a one-cycle done pulse. Sits between the request sources and the shared machine instance.

---
 rtl/ser_arb_pkg.sv | 16 +
 rtl/ser_shift_unit.sv | 86 ++++++++
 rtl/serial_stream_arbiter.sv | 107 ++++++++++
 tb/tb_serial_stream_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the two-requester serial stream arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package ser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ser_state_t;

    localparam int REQ0          = 0;
    localparam int REQ1          = 1;
    localparam int SER_W_DEFAULT = 8;

endpackage

// File: rtl/ser_shift_unit.sv
// Word shifter, bit counter and response capture; SER_PARITY_EN appends an odd-parity slot.
// Latency: one bit per shift cycle. Backpressure: none, the FSM paces load/shift.
module ser_shift_unit
    import ser_arb_pkg::*;
#(
    parameter int W  = SER_W_DEFAULT,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_shift,
    input  logic         i_y,
    output logic         o_bit,
    output logic         o_last,
    output logic [W-1:0] o_rsp,
    output logic         o_rsp_par
);

`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] LAST_C = CW'(W);
`else
    localparam logic [CW-1:0] LAST_C = CW'(W - 1);
`endif

    logic [W-1:0]  r_sr;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_rsp;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST_C);
    assign o_last = w_last;
    assign o_rsp  = r_rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_rsp <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr <= r_sr >> 1;
            if (!w_last)
                r_cnt <= r_cnt + 1'b1;
`ifdef SER_PARITY_EN
            // The parity slot must not disturb the already-complete data word.
            if (!w_last)
                r_acc <= {i_y, r_acc[W-1:1]};
            else
                r_rsp <= r_acc;
`else
            r_acc <= {i_y, r_acc[W-1:1]};
            if (w_last)
                r_rsp <= {i_y, r_acc[W-1:1]};
`endif
        end
    end

`ifdef SER_PARITY_EN
    logic r_par;
    logic r_rsp_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par     <= 1'b0;
            r_rsp_par <= 1'b0;
        end else if (i_load) begin
            r_par <= ~^i_data;
        end else if (i_shift && w_last) begin
            r_rsp_par <= i_y;
        end
    end

    assign o_bit     = w_last ? r_par : r_sr[0];
    assign o_rsp_par = r_rsp_par;
`else
    assign o_bit     = r_sr[0];
    assign o_rsp_par = 1'b0;
`endif

endmodule

// File: rtl/serial_stream_arbiter.sv
// Round-robin share of one serial X/Y machine between two requesters (SER_PARITY_EN adds parity bit).
// Latency: grant t+1, first bit t+2, done t+W+2 (t+W+3 with parity). Backpressure: req held until done.
module serial_stream_arbiter
    import ser_arb_pkg::*;
#(
    parameter int W  = SER_W_DEFAULT,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic [1:0]   gnt,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] rsp,
    output logic         rsp_par,
    output logic         busy,
    output logic         x_out,
    output logic         x_valid,
    input  logic         y_in
);

    ser_state_t   r_state;
    ser_state_t   w_state_nxt;
    logic [1:0]   r_gnt;
    logic         r_rr;
    logic         w_any;
    logic         w_win;
    logic [W-1:0] w_data;
    logic         w_load;
    logic         w_shift;
    logic         w_last;
    logic         w_bit;

    // r_rr holds the last winner; on a tie the other requester goes next.
    assign w_any  = req0 | req1;
    assign w_win  = (req0 & req1) ? ~r_rr : req1;
    assign w_data = w_win ? data1 : data0;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: w_state_nxt = SHIFT;
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= 2'b00;
            r_rr  <= 1'b1;
        end else if (w_load) begin
            r_gnt <= w_win ? 2'b10 : 2'b01;
        end else if (r_state == DONE) begin
            r_rr  <= r_gnt[REQ1];
            r_gnt <= 2'b00;
        end
    end

    ser_shift_unit #(
        .W  (W),
        .CW (CW)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_data    (w_data),
        .i_shift   (w_shift),
        .i_y       (y_in),
        .o_bit     (w_bit),
        .o_last    (w_last),
        .o_rsp     (rsp),
        .o_rsp_par (rsp_par)
    );

    assign gnt     = r_gnt;
    assign done0   = (r_state == DONE) & r_gnt[REQ0];
    assign done1   = (r_state == DONE) & r_gnt[REQ1];
    assign busy    = (r_state != IDLE);
    assign x_valid = (r_state == SHIFT);
    assign x_out   = x_valid & w_bit;

endmodule

// File: tb/tb_serial_stream_arbiter.sv
// Directed bench for serial_stream_arbiter with the shared machine modelled as Y = ~X.
module tb_serial_stream_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0;
    logic [W-1:0] data0;
    logic         req1;
    logic [W-1:0] data1;
    logic [1:0]   gnt;
    logic         done0;
    logic         done1;
    logic [W-1:0] rsp;
    logic         rsp_par;
    logic         busy;
    logic         x_out;
    logic         x_valid;
    logic         y_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign y_in = ~x_out;

    serial_stream_arbiter #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .data0   (data0),
        .req1    (req1),
        .data1   (data1),
        .gnt     (gnt),
        .done0   (done0),
        .done1   (done1),
        .rsp     (rsp),
        .rsp_par (rsp_par),
        .busy    (busy),
        .x_out   (x_out),
        .x_valid (x_valid),
        .y_in    (y_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in the GRANT cycle; returns in the DONE cycle.
    task automatic frame(input logic [1:0] eg, input logic [7:0] d, input logic [7:0] er,
                         input int drop_k);
        chk("grant_gnt", gnt, eg);
        chk("grant_xvalid", x_valid, 0);
        chk("grant_xout", x_out, 0);
        chk("grant_busy", busy, 1);
        chk("grant_done", {done1, done0}, 0);
        for (int k = 0; k < W; k++) begin
            tick;
            if (k == drop_k) begin
                req0  = 1'b0;
                data0 = 8'hFF;
            end
            chk($sformatf("xbit%0d", k), x_out, d[k]);
            chk("shift_xvalid", x_valid, 1);
            chk("shift_gnt", gnt, eg);
            chk("shift_done", {done1, done0}, 0);
        end
`ifdef SER_PARITY_EN
        tick;
        chk("xpar", x_out, ~^d);
        chk("par_xvalid", x_valid, 1);
        chk("par_done", {done1, done0}, 0);
`endif
        tick;
        chk("done_pulse", {done1, done0}, eg);
        chk("done_rsp", rsp, er);
`ifdef SER_PARITY_EN
        chk("done_rsp_par", rsp_par, ^d);
`else
        chk("done_rsp_par", rsp_par, 0);
`endif
        chk("done_gnt", gnt, eg);
        chk("done_xvalid", x_valid, 0);
        chk("done_busy", busy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", rsp, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_xvalid", x_valid, 0);
        chk("rst_xout", x_out, 0);
        chk("rst_rsp_par", rsp_par, 0);
        rst_n = 1'b1;

        // Single requester, basic frame.
        req0  = 1'b1;
        data0 = 8'hA5;
        tick;
        frame(2'b01, 8'hA5, 8'h5A, -1);
        req0 = 1'b0;
        tick;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gnt", gnt, 0);
        chk("t1_idle_done", done0, 0);

        // Simultaneous requests straight out of reset: requester 0 first.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h12;
        data1 = 8'h34;
        tick;
        frame(2'b01, 8'h12, 8'hED, -1);
        req0 = 1'b0;
        tick;
        chk("t2_gap_gnt", gnt, 0);
        chk("t2_gap_busy", busy, 0);
        tick;
        frame(2'b10, 8'h34, 8'hCB, -1);
        req1 = 1'b0;
        tick;
        chk("t2_end_busy", busy, 0);

        // Continuous contention alternates 0,1,0,1 with an IDLE gap each time.
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h5A;
        data1 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i % 2 == 0)
                frame(2'b01, 8'h5A, 8'hA5, -1);
            else
                frame(2'b10, 8'hC3, 8'h3C, -1);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick;
            chk("t3_gap_gnt", gnt, 0);
            chk("t3_gap_busy", busy, 0);
        end

        // Asynchronous reset in the middle of SHIFT, then full replay.
        req1  = 1'b1;
        data1 = 8'h3C;
        tick;
        chk("t4_gnt", gnt, 2'b10);
        for (int k = 0; k < 4; k++)
            tick;
        chk("t4_bit3", x_out, 1);
        chk("t4_bit3_xvalid", x_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_arst_gnt", gnt, 0);
        chk("t4_arst_xout", x_out, 0);
        chk("t4_arst_xvalid", x_valid, 0);
        chk("t4_arst_busy", busy, 0);
        chk("t4_arst_done", done1, 0);
        tick;
        rst_n = 1'b1;
        tick;
        frame(2'b10, 8'h3C, 8'hC3, -1);
        req1 = 1'b0;
        tick;
        chk("t4_end_busy", busy, 0);

        // req0 dropped and data0 changed mid-frame: latched word still used.
        req0  = 1'b1;
        data0 = 8'h0F;
        tick;
        frame(2'b01, 8'h0F, 8'hF0, 2);
        tick;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_gnt", gnt, 0);
        tick;
        chk("t5_stay_idle", busy, 0);
        chk("t5_rsp_hold", rsp, 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
